// File: rtl/mon_pkg.sv
// Shared definitions for the monitoring pipeline output stage.
// Holds the dispatcher state encoding and the default position of the dst field in tuser.
package mon_pkg;

    typedef enum logic [1:0] {
        WAIT_HIT = 2'd0,
        FWD      = 2'd1,
        DROP     = 2'd2,
        DISCARD  = 2'd3
    } mon_state_t;

    localparam int DST_PORT_POS_DEF = 24;

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO: dout always shows the head entry while not empty.
// Writes when full and reads when empty are ignored.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             nearly_full,
    output logic             empty
);

    localparam int DEPTH = 1 << MAX_DEPTH_BITS;

    logic [WIDTH-1:0]        mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
    logic [MAX_DEPTH_BITS:0]   depth;
    logic                      do_wr, do_rd;

    assign do_wr       = wr_en && !full;
    assign do_rd       = rd_en && !empty;
    assign empty       = (depth == '0);
    assign full        = (depth == (MAX_DEPTH_BITS+1)'(DEPTH));
    assign nearly_full = (depth >= (MAX_DEPTH_BITS+1)'(DEPTH - 1));
    assign dout        = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            depth  <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_rd)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_wr && !do_rd)
                depth <= depth + 1'b1;
            else if (!do_wr && do_rd)
                depth <= depth - 1'b1;
        end
    end

endmodule

// File: rtl/mon_sat_counter.sv
// Saturating statistics counter; a clear wins over a same-cycle increment.
module mon_sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/mon_output_dispatcher.sv
// Output stage: pairs each buffered packet with its lookup result, rewrites the tuser dst field,
// then forwards, drops or truncates the packet and keeps saturating statistics.
module mon_output_dispatcher
    import mon_pkg::*;
#(
    parameter int DATA_WIDTH          = 256,
    parameter int TUSER_WIDTH         = 128,
    parameter int NUM_PORTS           = 8,
    parameter int DST_PORT_POS        = DST_PORT_POS_DEF,
    parameter int PKT_FIFO_DEPTH_BITS = 4,
    parameter int HIT_FIFO_DEPTH_BITS = 3,
    parameter int SNAP_WIDTH          = 8,
    parameter int CNT_WIDTH           = 32
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic [TUSER_WIDTH-1:0]  s_axis_tuser,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,

    input  logic                    hit_valid,
    input  logic [NUM_PORTS-1:0]    hit_dst_ports,

    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic [TUSER_WIDTH-1:0]  m_axis_tuser,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,

    input  logic [NUM_PORTS-1:0]    port_mask,
    input  logic [SNAP_WIDTH-1:0]   snap_words,
    input  logic                    cnt_clear,
    output logic [CNT_WIDTH-1:0]    fwd_pkt_cnt,
    output logic [CNT_WIDTH-1:0]    drop_pkt_cnt,
    output logic [CNT_WIDTH-1:0]    trunc_pkt_cnt,
    output logic                    hit_overflow
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int PKT_W      = 1 + TUSER_WIDTH + STRB_WIDTH + DATA_WIDTH;

    mon_state_t state, state_nxt;

    logic [PKT_W-1:0]       pkt_dout;
    logic                   pkt_empty, pkt_nfull, pkt_full_unused;
    logic                   pop_pkt;
    logic                   head_last;
    logic [TUSER_WIDTH-1:0] head_user;
    logic [STRB_WIDTH-1:0]  head_strb;
    logic [DATA_WIDTH-1:0]  head_data;

    logic [NUM_PORTS-1:0]   hit_head, eff_dst;
    logic                   hit_empty, hit_full, hit_nfull_unused;
    logic                   pop_hit;

    logic [SNAP_WIDTH-1:0]  word_cnt, word_cnt_nxt;
    logic [SNAP_WIDTH:0]    word_cnt_inc;
    logic                   force_last, rewrite_dst;
    logic                   inc_fwd, inc_drop, inc_trunc;

    assign s_axis_tready = !pkt_nfull;

    fallthrough_small_fifo #(
        .WIDTH          (PKT_W),
        .MAX_DEPTH_BITS (PKT_FIFO_DEPTH_BITS)
    ) u_pkt_fifo (
        .clk         (clk),
        .reset       (reset),
        .din         ({s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata}),
        .wr_en       (s_axis_tvalid && s_axis_tready),
        .rd_en       (pop_pkt),
        .dout        (pkt_dout),
        .full        (pkt_full_unused),
        .nearly_full (pkt_nfull),
        .empty       (pkt_empty)
    );

    assign {head_last, head_user, head_strb, head_data} = pkt_dout;

    fallthrough_small_fifo #(
        .WIDTH          (NUM_PORTS),
        .MAX_DEPTH_BITS (HIT_FIFO_DEPTH_BITS)
    ) u_hit_fifo (
        .clk         (clk),
        .reset       (reset),
        .din         (hit_dst_ports),
        .wr_en       (hit_valid),
        .rd_en       (pop_hit),
        .dout        (hit_head),
        .full        (hit_full),
        .nearly_full (hit_nfull_unused),
        .empty       (hit_empty)
    );

    assign eff_dst      = hit_head & port_mask;
    assign word_cnt_inc = {1'b0, word_cnt} + (SNAP_WIDTH+1)'(1);

    always_comb begin
        state_nxt     = state;
        word_cnt_nxt  = word_cnt;
        pop_pkt       = 1'b0;
        pop_hit       = 1'b0;
        m_axis_tvalid = 1'b0;
        force_last    = 1'b0;
        rewrite_dst   = 1'b0;
        inc_fwd       = 1'b0;
        inc_drop      = 1'b0;
        inc_trunc     = 1'b0;
        case (state)
            WAIT_HIT: begin
                if (!pkt_empty && !hit_empty) begin
                    if (eff_dst != '0) begin
                        m_axis_tvalid = 1'b1;
                        rewrite_dst   = 1'b1;
                        force_last    = (snap_words == SNAP_WIDTH'(1));
                        if (m_axis_tready) begin
                            pop_pkt      = 1'b1;
                            word_cnt_nxt = SNAP_WIDTH'(1);
                            if (head_last) begin
                                pop_hit = 1'b1;
                                inc_fwd = 1'b1;
                            end else if (force_last) begin
                                pop_hit   = 1'b1;
                                inc_fwd   = 1'b1;
                                inc_trunc = 1'b1;
                                state_nxt = DISCARD;
                            end else begin
                                state_nxt = FWD;
                            end
                        end
                    end else begin
                        // No surviving destination: drain silently
                        pop_pkt = 1'b1;
                        if (head_last) begin
                            pop_hit  = 1'b1;
                            inc_drop = 1'b1;
                        end else begin
                            state_nxt = DROP;
                        end
                    end
                end
            end
            FWD: begin
                if (!pkt_empty) begin
                    m_axis_tvalid = 1'b1;
                    force_last    = (snap_words != '0) && (word_cnt_inc == {1'b0, snap_words});
                    if (m_axis_tready) begin
                        pop_pkt      = 1'b1;
                        word_cnt_nxt = word_cnt + SNAP_WIDTH'(1);
                        if (head_last) begin
                            pop_hit   = 1'b1;
                            inc_fwd   = 1'b1;
                            state_nxt = WAIT_HIT;
                        end else if (force_last) begin
                            pop_hit   = 1'b1;
                            inc_fwd   = 1'b1;
                            inc_trunc = 1'b1;
                            state_nxt = DISCARD;
                        end
                    end
                end
            end
            DROP: begin
                if (!pkt_empty) begin
                    pop_pkt = 1'b1;
                    if (head_last) begin
                        pop_hit   = 1'b1;
                        inc_drop  = 1'b1;
                        state_nxt = WAIT_HIT;
                    end
                end
            end
            DISCARD: begin
                // Hit was already consumed when the packet was cut short
                if (!pkt_empty) begin
                    pop_pkt = 1'b1;
                    if (head_last)
                        state_nxt = WAIT_HIT;
                end
            end
            default: state_nxt = WAIT_HIT;
        endcase
    end

    always_comb begin
        m_axis_tuser = head_user;
        if (rewrite_dst)
            m_axis_tuser[DST_PORT_POS +: NUM_PORTS] = eff_dst;
    end

    assign m_axis_tdata = head_data;
    assign m_axis_tstrb = head_strb;
    assign m_axis_tlast = head_last || force_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= WAIT_HIT;
            word_cnt <= '0;
        end else begin
            state    <= state_nxt;
            word_cnt <= word_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            hit_overflow <= 1'b0;
        else if (cnt_clear)
            hit_overflow <= 1'b0;
        else if (hit_valid && hit_full)
            hit_overflow <= 1'b1;
    end

    mon_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_fwd_cnt (
        .clk (clk), .reset (reset), .inc (inc_fwd), .clr (cnt_clear), .count (fwd_pkt_cnt)
    );

    mon_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_drop_cnt (
        .clk (clk), .reset (reset), .inc (inc_drop), .clr (cnt_clear), .count (drop_pkt_cnt)
    );

    mon_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_trunc_cnt (
        .clk (clk), .reset (reset), .inc (inc_trunc), .clr (cnt_clear), .count (trunc_pkt_cnt)
    );

endmodule

// File: tb/tb_mon_output_dispatcher.sv
// Directed bench for mon_output_dispatcher: vector table plus hand-written corner sequences.
module tb_mon_output_dispatcher;

    localparam int DW = 256;
    localparam int SW = DW / 8;
    localparam int TW = 128;
    localparam int NP = 8;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] s_axis_tdata;
    logic [SW-1:0] s_axis_tstrb;
    logic [TW-1:0] s_axis_tuser;
    logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic          hit_valid;
    logic [NP-1:0] hit_dst_ports;
    logic [DW-1:0] m_axis_tdata;
    logic [SW-1:0] m_axis_tstrb;
    logic [TW-1:0] m_axis_tuser;
    logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [NP-1:0] port_mask;
    logic [7:0]    snap_words;
    logic          cnt_clear;
    logic [CW-1:0] fwd_pkt_cnt, drop_pkt_cnt, trunc_pkt_cnt;
    logic          hit_overflow;

    logic bp_en, bp_rand, tready_man;
    assign m_axis_tready = bp_en ? bp_rand : tready_man;

    always #5 clk = ~clk;
    always @(posedge clk) bp_rand <= 1'($urandom_range(0, 1));

    mon_output_dispatcher dut (
        .clk (clk), .reset (reset),
        .s_axis_tdata (s_axis_tdata), .s_axis_tstrb (s_axis_tstrb), .s_axis_tuser (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid), .s_axis_tlast (s_axis_tlast), .s_axis_tready (s_axis_tready),
        .hit_valid (hit_valid), .hit_dst_ports (hit_dst_ports),
        .m_axis_tdata (m_axis_tdata), .m_axis_tstrb (m_axis_tstrb), .m_axis_tuser (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid), .m_axis_tlast (m_axis_tlast), .m_axis_tready (m_axis_tready),
        .port_mask (port_mask), .snap_words (snap_words), .cnt_clear (cnt_clear),
        .fwd_pkt_cnt (fwd_pkt_cnt), .drop_pkt_cnt (drop_pkt_cnt), .trunc_pkt_cnt (trunc_pkt_cnt),
        .hit_overflow (hit_overflow)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input int v, input int w);
        return {8{v[15:0], w[15:0]}};
    endfunction

    function automatic logic [TW-1:0] mk_user(input int v, input int w);
        return {64'hDEADBEEF_CAFEF00D, v, 8'h00, w[23:0]};
    endfunction

    function automatic logic [SW-1:0] mk_strb(input int w);
        return ~SW'(w);
    endfunction

    function automatic logic [TW-1:0] with_dst(input logic [TW-1:0] u, input logic [NP-1:0] d);
        logic [TW-1:0] r;
        r = u;
        r[24 +: NP] = d;
        return r;
    endfunction

    // Output capture, sampled mid-cycle
    logic [DW-1:0] cap_d[$];
    logic [TW-1:0] cap_u[$];
    logic [SW-1:0] cap_s[$];
    logic          cap_l[$];
    int            pkts_done = 0;
    bit            prev_stall = 1'b0;
    bit            saw_full = 1'b0;

    always @(negedge clk) begin
        if (!reset && prev_stall)
            chk("tvalid_hold", 256'(m_axis_tvalid), 256'd1);
        if (!reset && m_axis_tvalid && m_axis_tready) begin
            cap_d.push_back(m_axis_tdata);
            cap_u.push_back(m_axis_tuser);
            cap_s.push_back(m_axis_tstrb);
            cap_l.push_back(m_axis_tlast);
            if (m_axis_tlast) pkts_done++;
        end
        if (!reset && !s_axis_tready) saw_full = 1'b1;
        prev_stall = !reset && m_axis_tvalid && !m_axis_tready;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic hit_pulse(input logic [NP-1:0] h);
        hit_valid     = 1'b1;
        hit_dst_ports = h;
        tick();
        hit_valid     = 1'b0;
    endtask

    task automatic send_pkt(input int v, input int len, input bit last_on);
        bit ok;
        int n;
        for (int w = 0; w < len; w++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = mk_data(v, w);
            s_axis_tstrb  = mk_strb(w);
            s_axis_tuser  = mk_user(v, w);
            s_axis_tlast  = last_on && (w == len - 1);
            n = 0;
            do begin
                @(negedge clk);
                ok = s_axis_tready;
                @(posedge clk);
                #1;
                n++;
            end while (!ok && n < 2000);
            if (!ok) chk("s_axis_tready_timeout", 256'(ok), 256'd1);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic clear_cap;
        cap_d.delete(); cap_u.delete(); cap_s.delete(); cap_l.delete();
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    typedef struct {
        int         len;
        logic [7:0] hit, mask, snap;
        int         nw;
        logic [7:0] dst;
        int         fwd, drop, trunc;
    } vec_t;

    vec_t vt[9];

    logic [DW-1:0] exp_d[$];
    logic [TW-1:0] exp_u[$];
    logic          exp_l[$];

    initial begin
        // len, hit, mask, snap -> words out, dst, cumulative fwd/drop/trunc
        vt[0] = '{3, 8'h05, 8'hFF, 8'd0, 3, 8'h05, 1, 0, 0};
        vt[1] = '{2, 8'h0A, 8'h02, 8'd0, 2, 8'h02, 2, 0, 0};
        vt[2] = '{4, 8'h0A, 8'h05, 8'd0, 0, 8'h00, 2, 1, 0};
        vt[3] = '{5, 8'hFF, 8'hFF, 8'd2, 2, 8'hFF, 3, 1, 1};
        vt[4] = '{2, 8'h01, 8'hFF, 8'd2, 2, 8'h01, 4, 1, 1};
        vt[5] = '{1, 8'h80, 8'hFF, 8'd1, 1, 8'h80, 5, 1, 1};
        vt[6] = '{3, 8'h10, 8'hF0, 8'd1, 1, 8'h10, 6, 1, 2};
        vt[7] = '{1, 8'h03, 8'h0C, 8'd0, 0, 8'h00, 6, 2, 2};
        vt[8] = '{4, 8'h0C, 8'h0C, 8'd3, 3, 8'h0C, 7, 2, 3};

        reset = 1'b1;
        s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tdata = '0; s_axis_tstrb = '0; s_axis_tuser = '0;
        hit_valid = 0; hit_dst_ports = '0; port_mask = 8'hFF; snap_words = 8'd0; cnt_clear = 0;
        bp_en = 1'b0; tready_man = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("rst_tvalid", 256'(m_axis_tvalid), 256'd0);
        chk("rst_fwd", 256'(fwd_pkt_cnt), 256'd0);
        chk("rst_drop", 256'(drop_pkt_cnt), 256'd0);
        chk("rst_trunc", 256'(trunc_pkt_cnt), 256'd0);
        chk("rst_ovf", 256'(hit_overflow), 256'd0);
        chk("rst_s_tready", 256'(s_axis_tready), 256'd1);
        tick();
        reset = 1'b0;
        tick();

        // Table-driven vectors, downstream always ready
        for (int i = 0; i < 9; i++) begin
            clear_cap();
            port_mask  = vt[i].mask;
            snap_words = vt[i].snap;
            hit_pulse(vt[i].hit);
            send_pkt(i, vt[i].len, 1'b1);
            repeat (12) tick();
            @(negedge clk);
            chk($sformatf("v%0d_nwords", i), 256'(cap_d.size()), 256'(vt[i].nw));
            for (int w = 0; w < cap_d.size() && w < vt[i].nw; w++) begin
                chk($sformatf("v%0d_w%0d_data", i, w), 256'(cap_d[w]), 256'(mk_data(i, w)));
                chk($sformatf("v%0d_w%0d_strb", i, w), 256'(cap_s[w]), 256'(mk_strb(w)));
                chk($sformatf("v%0d_w%0d_last", i, w), 256'(cap_l[w]), 256'(w == vt[i].nw - 1));
                chk($sformatf("v%0d_w%0d_user", i, w), 256'(cap_u[w]),
                    256'((w == 0) ? with_dst(mk_user(i, w), vt[i].dst) : mk_user(i, w)));
            end
            chk($sformatf("v%0d_fwd", i), 256'(fwd_pkt_cnt), 256'(vt[i].fwd));
            chk($sformatf("v%0d_drop", i), 256'(drop_pkt_cnt), 256'(vt[i].drop));
            chk($sformatf("v%0d_trunc", i), 256'(trunc_pkt_cnt), 256'(vt[i].trunc));
            tick();
        end

        // Reset in the middle of a stalled packet discards everything
        port_mask = 8'hFF; snap_words = 8'd0; tready_man = 1'b0;
        hit_pulse(8'h01);
        send_pkt(50, 2, 1'b0);
        tick();
        @(negedge clk);
        chk("midpkt_tvalid", 256'(m_axis_tvalid), 256'd1);
        tick();
        do_reset();
        repeat (3) tick();
        @(negedge clk);
        chk("postrst_tvalid", 256'(m_axis_tvalid), 256'd0);
        chk("postrst_fwd", 256'(fwd_pkt_cnt), 256'd0);
        tick();
        tready_man = 1'b1;

        // Backpressure: 100 packets, initial full stall then random ready
        clear_cap();
        saw_full = 1'b0;
        tready_man = 1'b0;
        begin
            int base;
            int n;
            base = pkts_done;
            fork
                begin
                    for (int p = 0; p < 100; p++) begin
                        int len;
                        logic [7:0] h;
                        len = int'($urandom_range(1, 6));
                        h   = 8'($urandom_range(1, 255));
                        n = 0;
                        while ((base + p - pkts_done) >= 6 && n < 2000) begin tick(); n++; end
                        hit_pulse(h);
                        for (int w = 0; w < len; w++) begin
                            exp_d.push_back(mk_data(100 + p, w));
                            exp_u.push_back((w == 0) ? with_dst(mk_user(100 + p, w), h) : mk_user(100 + p, w));
                            exp_l.push_back(w == len - 1);
                        end
                        send_pkt(100 + p, len, 1'b1);
                    end
                end
                begin
                    repeat (60) tick();
                    bp_en = 1'b1;
                end
            join
            n = 0;
            while (pkts_done < base + 100 && n < 5000) begin tick(); n++; end
            @(negedge clk);
            chk("bp_pkts_done", 256'(pkts_done - base), 256'd100);
            chk("bp_nwords", 256'(cap_d.size()), 256'(exp_d.size()));
            for (int w = 0; w < cap_d.size() && w < exp_d.size(); w++) begin
                chk($sformatf("bp_w%0d_data", w), 256'(cap_d[w]), 256'(exp_d[w]));
                chk($sformatf("bp_w%0d_user", w), 256'(cap_u[w]), 256'(exp_u[w]));
                chk($sformatf("bp_w%0d_last", w), 256'(cap_l[w]), 256'(exp_l[w]));
            end
            chk("bp_s_tready_deasserted", 256'(saw_full), 256'd1);
            chk("bp_no_ovf", 256'(hit_overflow), 256'd0);
            chk("bp_fwd", 256'(fwd_pkt_cnt), 256'd100);
            tick();
        end
        bp_en = 1'b0;
        tready_man = 1'b1;

        // Hit FIFO overflow: 8 results fit, the 9th sets the sticky flag
        do_reset();
        for (int i = 0; i < 8; i++) hit_pulse(8'(i + 1));
        @(negedge clk);
        chk("ovf_after8", 256'(hit_overflow), 256'd0);
        tick();
        hit_pulse(8'h09);
        @(negedge clk);
        chk("ovf_after9", 256'(hit_overflow), 256'd1);
        tick();
        tick();
        @(negedge clk);
        chk("ovf_sticky", 256'(hit_overflow), 256'd1);
        tick();
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", 256'(hit_overflow), 256'd0);
        tick();

        // cnt_clear wins over a same-cycle forward
        do_reset();
        clear_cap();
        hit_pulse(8'h01);
        send_pkt(200, 1, 1'b1);
        repeat (5) tick();
        @(negedge clk);
        chk("clr_pre_fwd", 256'(fwd_pkt_cnt), 256'd1);
        tick();
        tready_man = 1'b0;
        hit_pulse(8'h02);
        send_pkt(201, 1, 1'b1);
        repeat (3) tick();
        @(negedge clk);
        chk("clr_stall_tvalid", 256'(m_axis_tvalid), 256'd1);
        tick();
        tready_man = 1'b1;
        cnt_clear  = 1'b1;
        tick();
        cnt_clear  = 1'b0;
        @(negedge clk);
        chk("clr_fwd", 256'(fwd_pkt_cnt), 256'd0);
        chk("clr_word_taken", 256'(cap_d.size()), 256'd2);
        chk("clr_word_data", 256'(cap_d[cap_d.size()-1]), 256'(mk_data(201, 0)));
        repeat (3) tick();
        @(negedge clk);
        chk("clr_fwd_stays0", 256'(fwd_pkt_cnt), 256'd0);
        chk("clr_idle_tvalid", 256'(m_axis_tvalid), 256'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
